// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM encoding
// and address-field width helpers.
package cache_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int ADDR_W   = 32;
    localparam int WORD_W   = 32;
    localparam int BYTE_BIT = 2;

    function automatic int tag_bits(input int set_bit, input int line_word_bit);
        return ADDR_W - set_bit - line_word_bit - BYTE_BIT;
    endfunction

    // Pointer width stays at least one bit so WAYS=1 still has legal vectors.
    function automatic int ptr_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction
endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and refill-side bus of the instruction cache.
interface icache_assoc_if;
    import cache_pkg::*;

    logic              fetch_valid_in;
    logic [ADDR_W-1:0] fetch_addr_in;
    logic              fetch_ready_out;
    logic              fetch_done_out;
    logic [WORD_W-1:0] fetch_data_out;
    logic              mem_req_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_data_valid_in;
    logic [WORD_W-1:0] mem_data_in;

    modport slave (
        input  fetch_valid_in, fetch_addr_in, mem_data_valid_in, mem_data_in,
        output fetch_ready_out, fetch_done_out, fetch_data_out, mem_req_out, mem_addr_out
    );

    modport master (
        output fetch_valid_in, fetch_addr_in, mem_data_valid_in, mem_data_in,
        input  fetch_ready_out, fetch_done_out, fetch_data_out, mem_req_out, mem_addr_out
    );
endinterface

// File: rtl/icache_assoc_way.sv
// One cache way: valid bits, tag and data arrays, with asynchronous lookup
// and tag compare for the incoming fetch address.
module icache_way import cache_pkg::*; #(
    parameter int SET_BIT       = 6,
    parameter int LINE_WORD_BIT = 1,
    parameter int TAG_W         = tag_bits(SET_BIT, LINE_WORD_BIT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_BIT-1:0]       rd_idx,
    input  logic [TAG_W-1:0]         rd_tag,
    input  logic [LINE_WORD_BIT-1:0] rd_off,
    output logic                     hit,
    output logic                     valid,
    output logic [WORD_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [SET_BIT-1:0]       wr_idx,
    input  logic [LINE_WORD_BIT-1:0] wr_off,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     fill,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic                     clear
);
    localparam int SETS  = 1 << SET_BIT;
    localparam int WORDS = 1 << LINE_WORD_BIT;

    logic [SETS-1:0]   vld;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS][WORDS];

    always_ff @(posedge clk) begin
        if (!rst)        vld <= '0;
        else if (clear)  vld <= '0;
        else if (fill)   vld[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill)  tags[wr_idx] <= fill_tag;
        if (wr_en) data[wr_idx][wr_off] <= wr_data;
    end

    assign valid   = vld[rd_idx];
    assign hit     = valid && (tags[rd_idx] == rd_tag);
    assign rd_data = data[rd_idx][rd_off];
endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: 1-cycle hits, line refill from memory,
// lowest-invalid / round-robin replacement, whole-cache flush.
module icache_assoc import cache_pkg::*; #(
    parameter int SET_BIT       = 6,
    parameter int WAYS          = 2,
    parameter int LINE_WORD_BIT = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    icache_assoc_if.slave bus
);
    localparam int TAG_W = tag_bits(SET_BIT, LINE_WORD_BIT);
    localparam int PTR_W = ptr_bits(WAYS);
    localparam int LO    = LINE_WORD_BIT + BYTE_BIT;

    state_t                   state;
    logic                     done, mem_req, flushing;
    logic [WORD_W-1:0]        data_q, resp_word, hit_word;
    logic [ADDR_W-1:0]        mem_addr;
    logic [SET_BIT-1:0]       fetch_idx, req_idx;
    logic [TAG_W-1:0]         fetch_tag, req_tag;
    logic [LINE_WORD_BIT-1:0] fetch_off, req_off, beat;
    logic [PTR_W-1:0]         victim, victim_q, rr_cur;
    logic [WAYS-1:0]          hit, vld;
    logic [WAYS-1:0][WORD_W-1:0] rd_data;
    logic                     accept, beat_in, last_beat, fill, unused;

    assign fetch_off = bus.fetch_addr_in[LO-1:BYTE_BIT];
    assign fetch_idx = bus.fetch_addr_in[LO +: SET_BIT];
    assign fetch_tag = bus.fetch_addr_in[ADDR_W-1 -: TAG_W];
    assign unused    = ^bus.fetch_addr_in[BYTE_BIT-1:0];

    assign accept    = rdy_in && (state == IDLE) && !flush_in && bus.fetch_valid_in;
    assign beat_in   = rdy_in && (state == REFILL) && bus.mem_data_valid_in;
    assign last_beat = beat_in && (&beat);
    // A flush seen at any point of the refill discards the incoming line.
    assign fill      = last_beat && !flush_in && !flushing;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(.SET_BIT(SET_BIT), .LINE_WORD_BIT(LINE_WORD_BIT), .TAG_W(TAG_W)) u_way (
            .clk(clk_in), .rst(rst_in),
            .rd_idx(fetch_idx), .rd_tag(fetch_tag), .rd_off(fetch_off),
            .hit(hit[w]), .valid(vld[w]), .rd_data(rd_data[w]),
            .wr_en(beat_in && (victim_q == PTR_W'(w))),
            .wr_idx(req_idx), .wr_off(beat), .wr_data(bus.mem_data_in),
            .fill(fill && (victim_q == PTR_W'(w))), .fill_tag(req_tag),
            .clear(rdy_in && flush_in)
        );
    end

    if (WAYS > 1) begin : g_rr
        logic [(1<<SET_BIT)-1:0][PTR_W-1:0] rr;
        always_ff @(posedge clk_in) begin
            if (!rst_in || (rdy_in && flush_in)) rr <= '0;
            else if (fill)                       rr[req_idx] <= rr[req_idx] + 1'b1;
        end
        assign rr_cur = rr[fetch_idx];
    end else begin : g_no_rr
        assign rr_cur = '0;
    end

    always_comb begin
        victim = rr_cur;
        for (int w = WAYS-1; w >= 0; w--)
            if (!vld[w]) victim = PTR_W'(w);
    end

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++)
            if (hit[w]) hit_word = hit_word | rd_data[w];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            done      <= 1'b0;
            data_q    <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            flushing  <= 1'b0;
            beat      <= '0;
            req_idx   <= '0;
            req_tag   <= '0;
            req_off   <= '0;
            victim_q  <= '0;
            resp_word <= '0;
        end else if (rdy_in) begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (|hit) begin
                        done   <= 1'b1;
                        data_q <= hit_word;
                    end else begin
                        req_idx  <= fetch_idx;
                        req_tag  <= fetch_tag;
                        req_off  <= fetch_off;
                        victim_q <= victim;
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {bus.fetch_addr_in[ADDR_W-1:LO], {LO{1'b0}}};
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush_in) flushing <= 1'b1;
                    if (beat_in) begin
                        if (beat == req_off) resp_word <= bus.mem_data_in;
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            mem_req  <= 1'b0;
                            flushing <= 1'b0;
                            state    <= fill ? RESP : IDLE;
                        end
                    end
                end
                RESP: begin
                    if (!flush_in) begin
                        done   <= 1'b1;
                        data_q <= resp_word;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fetch_ready_out = (state == IDLE) && !flush_in;
    assign bus.fetch_done_out  = done;
    assign bus.fetch_data_out  = data_q;
    assign bus.mem_req_out     = mem_req;
    assign bus.mem_addr_out    = mem_addr;
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed table, multi-cycle corner sequences and a
// randomized run against an abstract set/way cache model.
module tb_icache_assoc;
    import cache_pkg::*;

    localparam int SET_BIT = 6;
    localparam int WAYS    = 2;
    localparam int LWB     = 1;
    localparam int WORDS   = 1 << LWB;
    localparam int SETS    = 1 << SET_BIT;

    logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
    icache_assoc_if bus();

    icache_assoc #(.SET_BIT(SET_BIT), .WAYS(WAYS), .LINE_WORD_BIT(LWB)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Backing memory contents.
    function automatic logic [31:0] bword(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hAAAA_0000;
            32'h0000_1004: return 32'hBBBB_1111;
            default:       return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Abstract cache: which line tags each set holds, plus its rotating pointer.
    bit          m_valid [SETS][WAYS];
    logic [22:0] m_tag   [SETS][WAYS];
    int          m_rr    [SETS];

    function automatic int sidx(input logic [31:0] a);
        return int'(a[3 +: SET_BIT]);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[sidx(a)][w] && m_tag[sidx(a)][w] == a[31:9]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_fill(input logic [31:0] a);
        int s, v;
        s = sidx(a);
        v = -1;
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) v = m_rr[s];
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = a[31:9];
        m_rr[s]       = (m_rr[s] + 1) % WAYS;
    endtask

    task automatic m_flush;
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    // One fetch with the memory side served by the bench; lat counts cycles
    // from the accepting edge to the one that raises fetch_done_out.
    task automatic do_fetch(input logic [31:0] a, input int gap_max, input int stall,
                            output bit hit, output logic [31:0] data, output int lat);
        logic [31:0] base;
        int n;
        base = {a[31:3], 3'b000};
        hit  = 1'b0;
        data = '0;
        n = 0;
        while (!bus.fetch_ready_out && n < 20) begin tick; n++; end
        chk("ready", 32'(bus.fetch_ready_out), 32'd1);
        bus.fetch_valid_in = 1'b1;
        bus.fetch_addr_in  = a;
        tick;
        bus.fetch_valid_in = 1'b0;
        lat = 1;
        if (bus.fetch_done_out) begin
            hit  = 1'b1;
            data = bus.fetch_data_out;
            return;
        end
        chk("mem_req_up", 32'(bus.mem_req_out), 32'd1);
        chk("mem_addr", bus.mem_addr_out, base);
        for (int k = 0; k < WORDS; k++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin tick; lat++; end
            if (k == WORDS-1 && stall > 0) begin
                rdy = 1'b0;
                repeat (stall) begin
                    tick;
                    lat++;
                    chk("stall_req", 32'(bus.mem_req_out), 32'd1);
                    chk("stall_done", 32'(bus.fetch_done_out), 32'd0);
                    chk("stall_addr", bus.mem_addr_out, base);
                end
                rdy = 1'b1;
            end
            bus.mem_data_valid_in = 1'b1;
            bus.mem_data_in       = bword(base + 32'(4*k));
            tick;
            lat++;
            bus.mem_data_valid_in = 1'b0;
        end
        chk("mem_req_drop", 32'(bus.mem_req_out), 32'd0);
        n = 0;
        while (!bus.fetch_done_out && n < 4) begin tick; lat++; n++; end
        chk("resp_in_time", 32'(bus.fetch_done_out && n <= 2), 32'd1);
        data = bus.fetch_data_out;
    endtask

    task automatic fetch_chk(input logic [31:0] a, input int gap, input string nm);
        bit exp, h;
        logic [31:0] d;
        int l;
        exp = m_hit(a);
        do_fetch(a, gap, 0, h, d, l);
        chk({nm, "_hit"}, 32'(h), 32'(exp));
        chk({nm, "_data"}, d, bword(a));
        if (!exp) m_fill(a);
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs [8];
    int          base_lat, st_lat;
    bit          h;
    logic [31:0] d, a;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_valid_in    = 1'b0;
        bus.fetch_addr_in     = '0;
        bus.mem_data_valid_in = 1'b0;
        bus.mem_data_in       = '0;
        base_lat = 0;

        // Cold miss, hit, then three lines fighting over set 0.
        vecs[0] = '{32'h0000_1004, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_1000, 1'b1, 32'h0};
        vecs[2] = '{32'h0000_3000, 1'b0, 32'h0};
        vecs[3] = '{32'h0000_5000, 1'b0, 32'h0};
        vecs[4] = '{32'h0000_3000, 1'b1, 32'h0};
        vecs[5] = '{32'h0000_1004, 1'b0, 32'h0};
        vecs[6] = '{32'h0000_5004, 1'b1, 32'h0};
        vecs[7] = '{32'h0000_3000, 1'b0, 32'h0};
        for (int i = 0; i < 8; i++) vecs[i].data = bword(vecs[i].addr);

        repeat (3) tick;
        chk("rst_done", 32'(bus.fetch_done_out), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req_out), 32'd0);
        chk("rst_data", bus.fetch_data_out, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_out, 32'd0);
        rst_n = 1'b1;
        tick;
        chk("rst_ready", 32'(bus.fetch_ready_out), 32'd1);

        for (int i = 0; i < 8; i++) begin
            int l;
            do_fetch(vecs[i].addr, 0, 0, h, d, l);
            if (i == 0) base_lat = l;
            chk($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].hit));
            chk($sformatf("vec%0d_data", i), d, vecs[i].data);
            if (!vecs[i].hit) m_fill(vecs[i].addr);
        end

        // Three frozen cycles before the last beat.
        a = 32'h0000_7010;
        do_fetch(a, 0, 3, h, d, st_lat);
        chk("stall_hit", 32'(h), 32'd0);
        chk("stall_data", d, bword(a));
        chk("stall_delay", 32'(st_lat), 32'(base_lat + 3));
        m_fill(a);

        // Flush after the first beat: drain, no response, line discarded.
        a = 32'h0000_8024;
        bus.fetch_valid_in = 1'b1;
        bus.fetch_addr_in  = a;
        tick;
        bus.fetch_valid_in = 1'b0;
        chk("fl_req", 32'(bus.mem_req_out), 32'd1);
        bus.mem_data_valid_in = 1'b1;
        bus.mem_data_in       = bword(32'h0000_8020);
        tick;
        bus.mem_data_valid_in = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_ready", 32'(bus.fetch_ready_out), 32'd0);
        tick;
        flush = 1'b0;
        chk("fl_drain_req", 32'(bus.mem_req_out), 32'd1);
        bus.mem_data_valid_in = 1'b1;
        bus.mem_data_in       = bword(32'h0000_8024);
        tick;
        bus.mem_data_valid_in = 1'b0;
        chk("fl_req_drop", 32'(bus.mem_req_out), 32'd0);
        repeat (3) begin
            tick;
            chk("fl_no_done", 32'(bus.fetch_done_out), 32'd0);
        end
        m_flush;
        fetch_chk(a, 0, "fl_refetch");
        fetch_chk(32'h0000_7010, 0, "fl_old");

        // Flush wins over a simultaneous fetch.
        bus.fetch_valid_in = 1'b1;
        bus.fetch_addr_in  = 32'h0000_1000;
        flush = 1'b1;
        tick;
        bus.fetch_valid_in = 1'b0;
        flush = 1'b0;
        chk("flf_done", 32'(bus.fetch_done_out), 32'd0);
        chk("flf_req", 32'(bus.mem_req_out), 32'd0);
        m_flush;

        // Four consecutive words across two lines, one hit per cycle.
        fetch_chk(32'h0000_2000, 0, "b2b_fill0");
        fetch_chk(32'h0000_2008, 0, "b2b_fill1");
        for (int k = 0; k < 4; k++) begin
            bus.fetch_valid_in = 1'b1;
            bus.fetch_addr_in  = 32'h0000_2000 + 32'(4*k);
            tick;
            chk($sformatf("b2b%0d_done", k), 32'(bus.fetch_done_out), 32'd1);
            chk($sformatf("b2b%0d_data", k), bus.fetch_data_out, bword(32'h0000_2000 + 32'(4*k)));
        end
        bus.fetch_valid_in = 1'b0;

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                flush = 1'b1;
                tick;
                flush = 1'b0;
                m_flush;
            end
            a = 32'h0001_0000 | (32'($urandom_range(4, 0)) << 9) |
                (32'($urandom_range(3, 0)) << 3) | (32'($urandom_range(1, 0)) << 2);
            fetch_chk(a, 2, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a refill.
        fetch_chk(32'h0000_4000, 0, "rs_fill");
        fetch_chk(32'h0000_4004, 0, "rs_hit");
        bus.fetch_valid_in = 1'b1;
        bus.fetch_addr_in  = 32'h0000_6000;
        tick;
        bus.fetch_valid_in = 1'b0;
        chk("rs_req", 32'(bus.mem_req_out), 32'd1);
        bus.mem_data_valid_in = 1'b1;
        bus.mem_data_in       = bword(32'h0000_6000);
        tick;
        bus.mem_data_valid_in = 1'b0;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("rs_req_low", 32'(bus.mem_req_out), 32'd0);
        chk("rs_done_low", 32'(bus.fetch_done_out), 32'd0);
        chk("rs_ready", 32'(bus.fetch_ready_out), 32'd1);
        chk("rs_addr", bus.mem_addr_out, 32'd0);
        m_flush;
        fetch_chk(32'h0000_4000, 0, "rs_refetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
